// File: rtl/max7219_pkg.sv
// max7219_pkg
// Shared definitions for the MAX7219 daisy-chain driver: register address
// map, the sequencer state type, the shifter phase type and a word builder.
package max7219_pkg;

    localparam logic [3:0] REG_NOOP         = 4'h0;
    localparam logic [3:0] REG_DIGIT0       = 4'h1;
    localparam logic [3:0] REG_DECODE       = 4'h9;
    localparam logic [3:0] REG_INTENSITY    = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
    localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

    localparam int INIT_WORDS = 5;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        SEQ_INIT,
        SEQ_FRAME,
        SEQ_INTENSITY
    } seq_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SHIFT,
        PH_LATCH,
        PH_GAP
    } phase_e;

    function automatic logic [15:0] mk_word(input logic [3:0] addr, input logic [7:0] data);
        return {4'h0, addr, data};
    endfunction

endpackage

// File: rtl/max7219_word_shifter.sv
// max7219_word_shifter
// Shifts one parallel-loaded transaction (one 16-bit word per device, the
// top word goes out first, MSB first) and then pulses load.
// Per bit: clk low CLK_DIV cycles, then high CLK_DIV cycles; dout changes
// on the edge where clk falls. After the last bit: load high CLK_DIV
// cycles, then a CLK_DIV-cycle gap. Total length 32*N*CLK_DIV + 2*CLK_DIV.
// Ports:
//   i_clk, i_reset_n      clock, synchronous active-low reset
//   i_start, i_word       start a transaction with this parallel word
//   o_serial_dout/clk/load serial pins
//   o_shift_done          last bit finished (load rises next cycle)
//   o_latch_done          load high phase finished
//   o_done                last gap cycle; a new i_start may be given here
module max7219_word_shifter
    import max7219_pkg::*;
#(
    parameter int NUM_DEVICES = 1,
    parameter int CLK_DIV     = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic [16*NUM_DEVICES-1:0] i_word,
    output logic                      o_serial_dout,
    output logic                      o_serial_clk,
    output logic                      o_serial_load,
    output logic                      o_shift_done,
    output logic                      o_latch_done,
    output logic                      o_done
);

    localparam int W  = 16 * NUM_DEVICES;
    localparam int BW = $clog2(W);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT   = BW'(W - 1);
    localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);

    phase_e          phase_q, phase_d;
    logic [W-1:0]    sr_q, sr_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic            sclk_q, sclk_d;
    logic            load_q, load_d;
    logic            div_tc;

    assign div_tc = (div_q == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            phase_q <= PH_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        phase_d      = phase_q;
        sr_d         = sr_q;
        bit_d        = bit_q;
        div_d        = div_q;
        sclk_d       = sclk_q;
        load_d       = load_q;
        o_shift_done = 1'b0;
        o_latch_done = 1'b0;
        o_done       = 1'b0;

        case (phase_q)
            PH_IDLE: ;
            PH_SHIFT: begin
                if (!div_tc) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_RELOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == LAST_BIT) begin
                        sclk_d       = 1'b0;
                        load_d       = 1'b1;
                        phase_d      = PH_LATCH;
                        o_shift_done = 1'b1;
                    end else begin
                        // falling clk edge presents the next bit
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                        sr_d   = {sr_q[W-2:0], 1'b0};
                    end
                end
            end
            PH_LATCH: begin
                if (!div_tc) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d        = DIV_RELOAD;
                    load_d       = 1'b0;
                    phase_d      = PH_GAP;
                    o_latch_done = 1'b1;
                end
            end
            PH_GAP: begin
                if (!div_tc) begin
                    div_d = div_q - 1'b1;
                end else begin
                    phase_d = PH_IDLE;
                    o_done  = 1'b1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        // start wins so a back-to-back word can be loaded in the last gap cycle
        if (i_start) begin
            phase_d = PH_SHIFT;
            sr_d    = i_word;
            bit_d   = '0;
            div_d   = DIV_RELOAD;
            sclk_d  = 1'b0;
            load_d  = 1'b0;
        end
    end

    assign o_serial_dout = sr_q[W-1];
    assign o_serial_clk  = sclk_q;
    assign o_serial_load = load_q;

endmodule

// File: rtl/max7219_chain_driver.sv
// max7219_chain_driver
// Drives a chain of NUM_DEVICES MAX7219 drivers: runs the configuration
// sequence after reset, sends a digit frame per refresh strobe and a
// broadcast intensity word per intensity write.
// Ports:
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_en                      gates the start of new sequences
//   i_refresh_stb, i_digits   frame request and segment bytes
//   i_intensity(_wr)          run-time intensity update
//   o_busy, o_frame_done      status
//   o_serial_dout/clk/load    serial pins
//
// state    | meaning
// ST_INIT  | after reset: launch the first configuration word
// ST_IDLE  | waiting; intensity request beats refresh request
// ST_SHIFT | shifter clocking out the words of one transaction
// ST_LATCH | load pulse high
// ST_GAP   | load low gap; chain the next word or return to idle
module max7219_chain_driver
    import max7219_pkg::*;
#(
    parameter int         NUM_DEVICES   = 1,
    parameter int         DIGITS        = 8,
    parameter int         CLK_DIV       = 2,
    parameter logic [3:0] INTENSITY_RST = 4'h8
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_en,
    input  logic                             i_refresh_stb,
    input  logic [NUM_DEVICES*DIGITS*8-1:0]  i_digits,
    input  logic [3:0]                       i_intensity,
    input  logic                             i_intensity_wr,
    output logic                             o_busy,
    output logic                             o_frame_done,
    output logic                             o_serial_dout,
    output logic                             o_serial_clk,
    output logic                             o_serial_load
);

    localparam int WW = 16 * NUM_DEVICES;
    localparam int DB = NUM_DEVICES * DIGITS * 8;
    localparam logic [2:0] LAST_DIGIT = 3'(DIGITS - 1);
    localparam logic [2:0] LAST_INIT  = 3'(INIT_WORDS - 1);

    state_e          state_q, state_d;
    seq_e            seq_q, seq_d;
    logic [2:0]      idx_q, idx_d;
    logic [DB-1:0]   snap_q, snap_d;
    logic            ref_pend_q, ref_pend_d;
    logic            int_pend_q, int_pend_d;
    logic [3:0]      int_val_q, int_val_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    logic            sh_start;
    logic [WW-1:0]   sh_word;
    logic            sh_shift_done;
    logic            sh_latch_done;
    logic            sh_done;
    logic            more_words;
    logic            in_init;

    function automatic logic [WW-1:0] build_word(input seq_e       seq,
                                                 input logic [2:0] idx,
                                                 input logic [DB-1:0] dig,
                                                 input logic [3:0] inten);
        logic [15:0]   w;
        logic [WW-1:0] v;
        v = '0;
        w = mk_word(REG_NOOP, 8'h00);
        case (seq)
            SEQ_INIT: begin
                case (idx)
                    3'd0:    w = mk_word(REG_SHUTDOWN, 8'h01);
                    3'd1:    w = mk_word(REG_DISPLAY_TEST, 8'h00);
                    3'd2:    w = mk_word(REG_DECODE, 8'h00);
                    3'd3:    w = mk_word(REG_SCAN_LIMIT, 8'(DIGITS - 1));
                    default: w = mk_word(REG_INTENSITY, {4'h0, INTENSITY_RST});
                endcase
            end
            SEQ_INTENSITY: w = mk_word(REG_INTENSITY, {4'h0, inten});
            default:       w = mk_word(REG_NOOP, 8'h00);
        endcase
        // device d sits at slot d; the top slot is shifted first and so
        // ends up in the last device of the chain
        for (int d = 0; d < NUM_DEVICES; d++) begin
            if (seq == SEQ_FRAME)
                v[d*16 +: 16] = mk_word(REG_DIGIT0 + {1'b0, idx},
                                        dig[(d*DIGITS + int'(idx))*8 +: 8]);
            else
                v[d*16 +: 16] = w;
        end
        return v;
    endfunction

    assign more_words = ((seq_q == SEQ_INIT)  && (idx_q != LAST_INIT)) ||
                        ((seq_q == SEQ_FRAME) && (idx_q != LAST_DIGIT));
    assign in_init    = (seq_q == SEQ_INIT) && (state_q != ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= ST_INIT;
            seq_q        <= SEQ_INIT;
            idx_q        <= '0;
            snap_q       <= '0;
            ref_pend_q   <= 1'b0;
            int_pend_q   <= 1'b0;
            int_val_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            ref_pend_q   <= ref_pend_d;
            int_pend_q   <= int_pend_d;
            int_val_q    <= int_val_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        ref_pend_d   = ref_pend_q;
        int_pend_d   = int_pend_q;
        int_val_d    = int_val_q;
        frame_done_d = 1'b0;
        sh_start     = 1'b0;
        sh_word      = '0;

        case (state_q)
            ST_INIT: begin
                seq_d    = SEQ_INIT;
                idx_d    = '0;
                sh_start = 1'b1;
                sh_word  = build_word(SEQ_INIT, 3'd0, snap_q, int_val_q);
                state_d  = ST_SHIFT;
            end
            ST_IDLE: begin
                if (i_en && int_pend_q) begin
                    seq_d      = SEQ_INTENSITY;
                    idx_d      = '0;
                    int_pend_d = 1'b0;
                    sh_start   = 1'b1;
                    sh_word    = build_word(SEQ_INTENSITY, 3'd0, snap_q, int_val_q);
                    state_d    = ST_SHIFT;
                end else if (i_en && ref_pend_q) begin
                    // first digit word comes straight from the live input,
                    // which is also what the snapshot captures this cycle
                    seq_d      = SEQ_FRAME;
                    idx_d      = '0;
                    snap_d     = i_digits;
                    ref_pend_d = 1'b0;
                    sh_start   = 1'b1;
                    sh_word    = build_word(SEQ_FRAME, 3'd0, i_digits, int_val_q);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sh_shift_done) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (sh_latch_done) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (sh_done) begin
                    if (more_words) begin
                        idx_d    = idx_q + 3'd1;
                        sh_start = 1'b1;
                        sh_word  = build_word(seq_q, idx_q + 3'd1, snap_q, int_val_q);
                        state_d  = ST_SHIFT;
                    end else begin
                        state_d      = ST_IDLE;
                        frame_done_d = (seq_q == SEQ_FRAME);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        // new requests are applied after consumption so one arriving in the
        // same cycle as a start is kept for the next sequence
        if (i_intensity_wr) begin
            int_pend_d = 1'b1;
            int_val_d  = i_intensity;
        end
        if (i_refresh_stb && i_en && !in_init)
            ref_pend_d = 1'b1;
    end

    assign busy_d = (state_d != ST_IDLE);

    max7219_word_shifter #(
        .NUM_DEVICES (NUM_DEVICES),
        .CLK_DIV     (CLK_DIV)
    ) u_shifter (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (sh_start),
        .i_word        (sh_word),
        .o_serial_dout (o_serial_dout),
        .o_serial_clk  (o_serial_clk),
        .o_serial_load (o_serial_load),
        .o_shift_done  (sh_shift_done),
        .o_latch_done  (sh_latch_done),
        .o_done        (sh_done)
    );

    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_max7219_chain_driver.sv
// tb_max7219_chain_driver
// Two-device chain, 8 digits, CLK_DIV=2 (T = 132 cycles per transaction).
// A pin-level monitor decodes every latched 32-bit transaction; the
// expected words are produced from the register map and the frame rules.
module tb_max7219_chain_driver;

    localparam int N  = 2;
    localparam int DG = 8;
    localparam int CD = 2;
    localparam int T  = 32 * N * CD + 2 * CD;
    localparam int DB = N * DG * 8;
    localparam logic [3:0] IRST = 4'h8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          stb = 1'b0;
    logic          iwr = 1'b0;
    logic [3:0]    inten = 4'h0;
    logic [DB-1:0] digits = '0;
    logic          busy, fd, dout, sclk, load;

    max7219_chain_driver #(
        .NUM_DEVICES   (N),
        .DIGITS        (DG),
        .CLK_DIV       (CD),
        .INTENSITY_RST (IRST)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_en           (en),
        .i_refresh_stb  (stb),
        .i_digits       (digits),
        .i_intensity    (inten),
        .i_intensity_wr (iwr),
        .o_busy         (busy),
        .o_frame_done   (fd),
        .o_serial_dout  (dout),
        .o_serial_clk   (sclk),
        .o_serial_load  (load)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- pin monitor ----------------
    logic [31:0] shreg = '0;
    int          nbits = 0;
    logic        psclk = 1'b0, pload = 1'b0, pfd = 1'b0;
    logic [31:0] cap_w[$];
    int          cap_c[$];
    int          cap_n[$];
    int          fd_c[$];
    logic        fd_busy[$];
    int          fd_high = 0;
    int          busy_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits = 0;
        end else begin
            if (sclk && !psclk) begin
                shreg = {shreg[30:0], dout};
                nbits++;
            end
            if (load && !pload) begin
                cap_w.push_back(shreg);
                cap_c.push_back(cyc);
                cap_n.push_back(nbits);
                nbits = 0;
            end
            if (fd && !pfd) begin
                fd_c.push_back(cyc);
                fd_busy.push_back(busy);
            end
        end
        if (fd) fd_high++;
        if (busy) busy_cnt++;
        psclk = sclk;
        pload = load;
        pfd   = fd;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int failures = 0;
    logic [31:0] exp_w[$];
    int rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] capw(input int i);
        return (i < cap_w.size()) ? cap_w[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int capc(input int i);
        return (i < cap_c.size()) ? cap_c[i] : -1;
    endfunction

    function automatic logic [31:0] bcast(input logic [15:0] w);
        return {N{w}};
    endfunction

    task automatic push_init();
        exp_w.push_back(bcast(16'h0C01));
        exp_w.push_back(bcast(16'h0F00));
        exp_w.push_back(bcast(16'h0900));
        exp_w.push_back(bcast({8'h0B, 8'(DG - 1)}));
        exp_w.push_back(bcast({8'h0A, 4'h0, IRST}));
    endtask

    // last device's word is shifted first, so it ends up in the upper half
    task automatic push_frame(input logic [DB-1:0] dv);
        for (int k = 1; k <= DG; k++) begin
            logic [31:0] w;
            w = '0;
            for (int d = N - 1; d >= 0; d--)
                w = (w << 16) | {16'h0, 8'(k), dv[(d*DG + k - 1)*8 +: 8]};
            exp_w.push_back(w);
        end
    endtask

    function automatic logic [DB-1:0] rand_digits();
        logic [DB-1:0] v;
        for (int i = 0; i < N * DG; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic wait_loads(input string tag, input int n, input int budget);
        int b = 0;
        while (cap_w.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_arrive"}, 32'(cap_w.size() >= n), 32'd1);
    endtask

    task automatic wait_fd(input string tag, input int n, input int budget);
        int b = 0;
        while (fd_c.size() < n && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_frame_done_arrive"}, 32'(fd_c.size() >= n), 32'd1);
    endtask

    task automatic compare_new(input string tag);
        for (int i = rd; i < exp_w.size(); i++)
            chk($sformatf("%s_w%0d", tag, i - rd), capw(i), exp_w[i]);
        chk({tag, "_count"}, 32'(cap_w.size()), 32'(exp_w.size()));
        rd = exp_w.size();
    endtask

    task automatic chk_timing(input string tag, input int first, input int n);
        int bad_sp = 0;
        int bad_bits = 0;
        for (int i = first; i < first + n; i++) begin
            if (i >= cap_n.size() || cap_n[i] != 32) bad_bits++;
            if (i > first && (capc(i) - capc(i - 1)) != T) bad_sp++;
        end
        chk({tag, "_spacing_errs"}, 32'(bad_sp), 32'd0);
        chk({tag, "_bitcount_errs"}, 32'(bad_bits), 32'd0);
    endtask

    task automatic pulse_stb();
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(60000 * 10);
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int s, f0, h0, b0, first;
        logic [DB-1:0] dv_a, dv_b;

        rst_n = 1'b0;
        en    = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_outputs", {27'h0, busy, fd, dout, sclk, load}, 32'h0);

        // init sequence after reset
        rst_n = 1'b1;
        push_init();
        first = cap_w.size();
        wait_loads("init", 5, 5 * T + 40);
        repeat (2 * CD + 2) @(negedge clk);
        chk("init_busy_low", 32'(busy), 32'd0);
        compare_new("init");
        chk_timing("init", first, 5);

        // fixed frame: device0 = 0x30, device1 = 0x6D
        for (int k = 0; k < DG; k++) begin
            digits[(0*DG + k)*8 +: 8] = 8'h30;
            digits[(1*DG + k)*8 +: 8] = 8'h6D;
        end
        push_frame(digits);
        f0 = fd_c.size();
        h0 = fd_high;
        first = cap_w.size();
        s = cyc;
        pulse_stb();
        wait_loads("fixed", first + 1, T + 10);
        chk("fixed_busy_mid", 32'(busy), 32'd1);
        s = capc(first) - s - 32 * N * CD;
        chk("fixed_start_latency", 32'(s >= 1 && s <= 3), 32'd1);
        wait_loads("fixed", first + 8, 8 * T + 20);
        wait_fd("fixed", f0 + 1, 4 * CD + 10);
        repeat (4) @(negedge clk);
        chk("fixed_fd_count", 32'(fd_c.size() - f0), 32'd1);
        chk("fixed_fd_width", 32'(fd_high - h0), 32'd1);
        chk("fixed_fd_cycle", 32'((f0 < fd_c.size()) ? fd_c[f0] : -1),
            32'(capc(first + 7) + 2 * CD));
        chk("fixed_busy_at_fd", 32'((f0 < fd_busy.size()) ? fd_busy[f0] : 1'b1), 32'd0);
        compare_new("fixed");
        chk_timing("fixed", first, 8);

        // intensity write + strobe mid-frame, digits changed after snapshot
        dv_a = rand_digits();
        dv_b = rand_digits();
        digits = dv_a;
        push_frame(dv_a);
        exp_w.push_back(bcast(16'h0A03));
        push_frame(dv_b);
        f0 = fd_c.size();
        first = cap_w.size();
        pulse_stb();
        wait_loads("mix", first + 3, 3 * T + 10);
        digits = dv_b;
        inten = 4'h3;
        iwr = 1'b1;
        @(negedge clk);
        iwr = 1'b0;
        inten = 4'h0;
        repeat (7) @(negedge clk);
        pulse_stb();
        wait_loads("mix", first + 17, 15 * T + 40);
        repeat (2 * CD + 4) @(negedge clk);
        compare_new("mix");
        chk_timing("mix_frame1", first, 8);
        chk_timing("mix_frame2", first + 9, 8);
        chk("mix_fd_count", 32'(fd_c.size() - f0), 32'd2);
        chk("mix_busy_low", 32'(busy), 32'd0);

        // three strobes during a frame collapse to one extra frame
        dv_a = rand_digits();
        dv_b = rand_digits();
        digits = dv_a;
        push_frame(dv_a);
        push_frame(dv_b);
        f0 = fd_c.size();
        first = cap_w.size();
        pulse_stb();
        wait_loads("merge", first + 1, T + 10);
        digits = dv_b;
        pulse_stb();
        repeat ($urandom_range(10, 60)) @(negedge clk);
        pulse_stb();
        wait_loads("merge", first + 4, 3 * T + 10);
        pulse_stb();
        wait_loads("merge", first + 16, 12 * T + 40);
        repeat (3 * T) @(negedge clk);
        compare_new("merge");
        chk("merge_fd_count", 32'(fd_c.size() - f0), 32'd2);

        // enable dropped mid-frame: frame completes, nothing new starts
        dv_a = rand_digits();
        digits = dv_a;
        push_frame(dv_a);
        f0 = fd_c.size();
        first = cap_w.size();
        pulse_stb();
        wait_loads("en_off", first + 2, 2 * T + 10);
        en = 1'b0;
        digits = rand_digits();
        wait_loads("en_off", first + 8, 6 * T + 20);
        repeat (3 * T) @(negedge clk);
        compare_new("en_off");
        chk("en_off_fd_count", 32'(fd_c.size() - f0), 32'd1);
        chk("en_off_busy_low", 32'(busy), 32'd0);
        b0 = busy_cnt;
        pulse_stb();
        repeat (300) @(negedge clk);
        chk("disabled_busy_cycles", 32'(busy_cnt - b0), 32'd0);
        compare_new("disabled");

        // reset in the middle of the 5th bit of a word, then full init again
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s = 0;
        while (nbits < 4 && s < 40 * CD) begin
            @(negedge clk);
            s++;
        end
        chk("abort_reached_bit5", 32'(nbits >= 4), 32'd1);
        repeat (CD + 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {27'h0, busy, fd, dout, sclk, load}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_init();
        first = cap_w.size();
        wait_loads("reinit", first + 5, 5 * T + 40);
        repeat (2 * CD + 2) @(negedge clk);
        chk("reinit_busy_low", 32'(busy), 32'd0);
        compare_new("reinit");
        chk_timing("reinit", first, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
